rank_order_encoder: RTL and testbench

- Parametrised rank-order (intensity-to-latency) input encoder.
- Snapshots an image on NEW_IMAGE and emits pixel indices brightest-first. Ties are emitted in ascending index order. Each index is handed to the AER output stage over a valid/ready handshake.
- Compares LANES pixels per cycle.
- Sits between the image source and the AER output controller.

---
 rtl/snn_enc_pkg.sv | 22 ++
 rtl/rank_order_encoder_if.sv | 28 ++
 rtl/rank_order_encoder_lane_pe.sv | 29 ++
 rtl/rank_order_encoder.sv | 223 ++++++++++++++++++++++
 tb/tb_rank_order_encoder.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/snn_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snn_enc_pkg
// Brief    : Shared types and helpers for the rank-order input encoder.
// Revision : 1.0 - initial release
// ============================================================================
package snn_enc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } enc_state_t;

    // $clog2 clamped to at least one bit so single-lane builds keep a legal width
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rank_order_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : rank_order_encoder_if
// Brief    : Valid/ready index channel from the encoder to the AER output stage.
// Revision : 1.0 - initial release
// ============================================================================
interface rank_order_encoder_if #(
    parameter int IDX_W = 4
) ();

    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_index;

    modport master (
        output out_valid,
        output out_index,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_index,
        output out_ready
    );

endinterface
`default_nettype wire

// File: rtl/rank_order_encoder_lane_pe.sv
`default_nettype none
// ============================================================================
// Module   : lane_priority_enc
// Brief    : Lowest-set-bit index and nonzero flag over a LANES-wide mask.
// Revision : 1.0 - initial release
// ============================================================================
module lane_priority_enc #(
    parameter int LANES  = 4,
    parameter int LANE_W = 2
) (
    input  wire logic [LANES-1:0]  mask,
    output logic      [LANE_W-1:0] idx,
    output logic                   nonzero
);

    // Scan high to low so the lowest set bit is the last one written
    always_comb begin
        idx = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = LANE_W'(i);
            end
        end
    end

    assign nonzero = |mask;

endmodule
`default_nettype wire

// File: rtl/rank_order_encoder.sv
`default_nettype none
// ============================================================================
// Module   : rank_order_encoder
// Brief    : Snapshots an image and emits pixel indices brightest-first,
//            ties in ascending index order, over a valid/ready channel.
//            Optional macro SORTER_THRESHOLD_EN adds a minimum-intensity floor.
// Revision : 1.0 - initial release
// ============================================================================
module rank_order_encoder
    import snn_enc_pkg::*;
#(
    parameter int IMAGE_SIZE      = 16,
    parameter int PIXEL_MAX_VALUE = 255,
    parameter int LANES           = 4,
    parameter int IDX_W           = $clog2(IMAGE_SIZE),
    parameter int PIX_W           = $clog2(PIXEL_MAX_VALUE + 1)
) (
    input  wire logic                               clk,
    input  wire logic                               rst_n,
    input  wire logic [IMAGE_SIZE-1:0][PIX_W-1:0]   image,
    input  wire logic                               new_image,
`ifdef SORTER_THRESHOLD_EN
    input  wire logic [PIX_W-1:0]                   threshold,
`endif
    rank_order_encoder_if.master                    aer,
    output logic                                    busy,
    output logic                                    image_encoded
);

    localparam int LANE_W = safe_clog2(LANES);
    localparam int SUM_W  = IDX_W + 1;

    localparam logic [SUM_W-1:0] C_SIZE    = SUM_W'(IMAGE_SIZE);
    localparam logic [SUM_W-1:0] C_LANES   = SUM_W'(LANES);
    localparam logic [SUM_W-1:0] C_ONE     = SUM_W'(1);
    localparam logic [PIX_W-1:0] C_PIX_MAX = PIX_W'(PIXEL_MAX_VALUE);
    localparam logic [PIX_W-1:0] C_PIX_ONE = PIX_W'(1);
    localparam logic [LANES-1:0] C_LN_ONE  = LANES'(1);

    enc_state_t                     r_state;
    enc_state_t                     w_state_nxt;
    logic [IMAGE_SIZE-1:0][PIX_W-1:0] r_image;
    logic [PIX_W-1:0]               r_intensity;
    logic [PIX_W-1:0]               w_intensity_nxt;
    logic [PIX_W-1:0]               w_floor;
    logic [IDX_W-1:0]               r_base;
    logic [IDX_W-1:0]               w_base_nxt;
    logic [SUM_W-1:0]               r_count;
    logic [SUM_W-1:0]               w_count_nxt;
    logic [LANES-1:0]               r_mask;
    logic [LANES-1:0]               w_mask_nxt;
    logic [LANES-1:0]               w_match;
    logic [LANES-1:0]               w_pe_in;
    logic [LANE_W-1:0]              w_pe_idx;
    logic                           w_pe_nz;
    logic [SUM_W-1:0]               w_base_step;
    logic                           w_last_group;
    logic                           w_at_floor;
    logic                           w_do_advance;
    logic                           w_accept;
    logic [IDX_W-1:0]               r_out_index;
    logic [IDX_W-1:0]               w_out_index_nxt;
    logic                           r_out_valid;
    logic                           r_busy;
    logic                           r_image_encoded;

`ifdef SORTER_THRESHOLD_EN
    logic [PIX_W-1:0]               r_threshold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_threshold <= '0;
        end else if (w_accept) begin
            r_threshold <= threshold;
        end
    end

    assign w_floor = r_threshold;
`else
    assign w_floor = '0;
`endif

    // Lanes that fall past the end of the image never match
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [SUM_W-1:0] w_pos;
        assign w_pos      = {1'b0, r_base} + SUM_W'(l);
        assign w_match[l] = (w_pos < C_SIZE) &&
                            (r_image[w_pos[IDX_W-1:0]] == r_intensity);
    end

    assign w_base_step  = {1'b0, r_base} + C_LANES;
    assign w_last_group = (w_base_step >= C_SIZE);
    assign w_at_floor   = (r_intensity <= w_floor);

    lane_priority_enc #(
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_pe (
        .mask    (w_pe_in),
        .idx     (w_pe_idx),
        .nonzero (w_pe_nz)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_intensity_nxt = r_intensity;
        w_base_nxt      = r_base;
        w_count_nxt     = r_count;
        w_mask_nxt      = r_mask;
        w_pe_in         = '0;
        w_do_advance    = 1'b0;
        w_accept        = 1'b0;

        case (r_state)
            IDLE: begin
                if (new_image) begin
                    w_accept        = 1'b1;
                    w_state_nxt     = SCAN;
                    w_intensity_nxt = C_PIX_MAX;
                    w_base_nxt      = '0;
                    w_count_nxt     = '0;
                    w_mask_nxt      = '0;
                end
            end
            SCAN: begin
                w_pe_in = w_match;
                if (w_pe_nz) begin
                    w_mask_nxt  = w_match;
                    w_state_nxt = EMIT;
                end else begin
                    w_do_advance = 1'b1;
                end
            end
            EMIT: begin
                if (aer.out_ready) begin
                    // Drop the lowest set bit: the index just handed over
                    w_pe_in     = r_mask & (r_mask - C_LN_ONE);
                    w_mask_nxt  = w_pe_in;
                    w_count_nxt = r_count + C_ONE;
                    if (r_count + C_ONE == C_SIZE) begin
                        w_state_nxt = DONE;
                    end else if (!w_pe_nz) begin
                        w_do_advance = 1'b1;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_do_advance) begin
            if (w_last_group) begin
                w_base_nxt = '0;
                if (w_at_floor) begin
                    w_state_nxt = DONE;
                end else begin
                    w_intensity_nxt = r_intensity - C_PIX_ONE;
                    w_state_nxt     = SCAN;
                end
            end else begin
                w_base_nxt  = w_base_step[IDX_W-1:0];
                w_state_nxt = SCAN;
            end
        end
    end

    // Output index is registered; it holds while the consumer stalls
    always_comb begin
        w_out_index_nxt = '0;
        if (w_state_nxt == EMIT) begin
            if (r_state == EMIT && !aer.out_ready) begin
                w_out_index_nxt = r_out_index;
            end else begin
                w_out_index_nxt = r_base + IDX_W'(w_pe_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_image         <= '0;
            r_intensity     <= '0;
            r_base          <= '0;
            r_count         <= '0;
            r_mask          <= '0;
            r_out_valid     <= 1'b0;
            r_out_index     <= '0;
            r_busy          <= 1'b0;
            r_image_encoded <= 1'b0;
        end else begin
            if (w_accept) begin
                r_image <= image;
            end
            r_intensity     <= w_intensity_nxt;
            r_base          <= w_base_nxt;
            r_count         <= w_count_nxt;
            r_mask          <= w_mask_nxt;
            r_out_valid     <= (w_state_nxt == EMIT);
            r_out_index     <= w_out_index_nxt;
            r_busy          <= (w_state_nxt != IDLE);
            r_image_encoded <= (w_state_nxt == DONE);
        end
    end

    assign aer.out_valid  = r_out_valid;
    assign aer.out_index  = r_out_index;
    assign busy           = r_busy;
    assign image_encoded  = r_image_encoded;

endmodule
`default_nettype wire

// File: tb/tb_rank_order_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rank_order_encoder
// Brief    : Directed scoreboard bench for rank_order_encoder (6 px, 4 lanes).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rank_order_encoder;

    localparam int IS   = 6;
    localparam int LN   = 4;
    localparam int PMAX = 200;
    localparam int IW   = 3;
    localparam int PW   = 8;

    typedef logic [IS-1:0][PW-1:0] img_t;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic new_image = 1'b0;
    img_t image     = '0;
    logic busy;
    logic image_encoded;
`ifdef SORTER_THRESHOLD_EN
    logic [PW-1:0] threshold = '0;
`endif

    rank_order_encoder_if #(.IDX_W(IW)) aer ();

    always #5 clk = ~clk;

    rank_order_encoder #(
        .IMAGE_SIZE      (IS),
        .PIXEL_MAX_VALUE (PMAX),
        .LANES           (LN),
        .IDX_W           (IW),
        .PIX_W           (PW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .image         (image),
        .new_image     (new_image),
`ifdef SORTER_THRESHOLD_EN
        .threshold     (threshold),
`endif
        .aer           (aer.master),
        .busy          (busy),
        .image_encoded (image_encoded)
    );

    int          n_pass  = 0;
    int          n_total = 0;
    int          exp_q[$];
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [IW-1:0] prev_idx = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic img_t mk(input int a0, input int a1, input int a2,
                                input int a3, input int a4, input int a5);
        img_t r;
        r[0] = PW'(a0); r[1] = PW'(a1); r[2] = PW'(a2);
        r[3] = PW'(a3); r[4] = PW'(a4); r[5] = PW'(a5);
        return r;
    endfunction

    // Reference order: descending intensity from the legal maximum to the floor, ascending index within a value
    task automatic push_model(input img_t img, input int floor_v);
        for (int v = PMAX; v >= floor_v; v--) begin
            for (int i = 0; i < IS; i++) begin
                if (int'(img[i]) == v) exp_q.push_back(i);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_valid && !prev_ready) begin
                chk("hold_valid", 32'(aer.out_valid), 1);
                chk("hold_index", 32'(aer.out_index), 32'(prev_idx));
            end
            if (aer.out_valid && aer.out_ready) begin
                int e;
                chk("hs_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("hs_index", 32'(aer.out_index), e);
                end
            end
            prev_valid = aer.out_valid;
            prev_ready = aer.out_ready;
            prev_idx   = aer.out_index;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input img_t img, input int floor_v);
        push_model(img, floor_v);
        image     = img;
        new_image = 1'b1;
        tick();
        new_image = 1'b0;
        @(negedge clk);
        chk("busy_after_accept", 32'(busy), 1);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        bit seen = 0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (aer.out_valid) begin
                seen = 1;
                break;
            end
        end
        chk({tag, "_valid_seen"}, 32'(seen), 1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (image_encoded) begin
                seen = 1;
                break;
            end
        end
        chk({tag, "_done_pulse"}, 32'(seen), 1);
        if (seen) begin
            chk({tag, "_busy_in_done"}, 32'(busy), 1);
            chk({tag, "_queue_drained"}, exp_q.size(), 0);
            @(negedge clk);
            chk({tag, "_pulse_width"}, 32'(image_encoded), 0);
            chk({tag, "_busy_drop"}, 32'(busy), 0);
        end
        exp_q.delete();
    endtask

    initial begin
        aer.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 32'(aer.out_valid), 0);
        chk("rst_index", 32'(aer.out_index), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_encoded", 32'(image_encoded), 0);
        rst_n = 1'b1;
        tick();

        // Full first group at one value, then partial second group
        start(mk(7, 7, 7, 7, 2, 7), 0);
        wait_valid("t2", 600);
        for (int k = 0; k < 4; k++) begin
            chk("t2_back_to_back", 32'(aer.out_valid), 1);
            @(negedge clk);
        end
        wait_done("t2", 600);

        // Ties, value-0 pixel last
        start(mk(3, 9, 1, 9, 0, 5), 0);
        wait_done("t1", 1000);

        // Backpressure, plus image change after accept
        aer.out_ready = 1'b0;
        start(mk(10, 20, 30, 40, 50, 60), 0);
        image = mk(0, 0, 0, 0, 0, 0);
        wait_valid("t3", 600);
        repeat (5) @(negedge clk);
        aer.out_ready = 1'b1;
        wait_done("t3", 1000);

        // NEW_IMAGE while busy is ignored and not queued
        start(mk(50, 40, 50, 30, 40, 60), 0);
        wait_valid("t4", 600);
        image     = mk(1, 2, 3, 4, 5, 6);
        new_image = 1'b1;
        @(negedge clk);
        new_image = 1'b0;
        wait_done("t4", 1000);
        repeat (3) begin
            @(negedge clk);
            chk("t4_not_queued", 32'(busy), 0);
        end

        // Pixels above the legal maximum: scan ends by exhaustion
        start(mk(250, 5, 250, 5, 201, 0), 0);
        wait_done("overmax", 1000);

        // Reset during EMIT
        start(mk(100, 90, 80, 70, 60, 50), 0);
        wait_valid("t5", 600);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(aer.out_valid), 0);
        chk("t5_rst_index", 32'(aer.out_index), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_encoded", 32'(image_encoded), 0);
        exp_q.delete();
        repeat (2) begin
            @(negedge clk);
            chk("t5_no_pulse", 32'(image_encoded), 0);
        end
        rst_n = 1'b1;
        tick();
        start(mk(5, 5, 5, 5, 5, 5), 0);
        wait_done("t5_fresh", 1000);

`ifdef SORTER_THRESHOLD_EN
        threshold = 8'd5;
        start(mk(6, 2, 5, 4, 7, 1), 5);
        wait_done("t6", 1000);
        threshold = 8'd0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
